// File: rtl/stripe_pkg.sv
// Shared definitions for the stripe/unstripe lane pair:
// default widths and the lane selector state encoding.
package stripe_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int DEPTH_DEF = 4;

    typedef enum logic {
        EXPECT0 = 1'b0,
        EXPECT1 = 1'b1
    } sel_state_e;

endpackage

// File: rtl/unstripe_lane_fifo.sv
// Per-lane word FIFO for unstripe: power-of-two depth,
// natural pointer wrap, synchronous active-low reset.
module lane_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [AW:0]      cnt_q;
    logic [WIDTH-1:0] mem_q [DEPTH];

    // Storage array; contents need no reset since count gates reads.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            if (push && !pop) begin
                cnt_q <= cnt_q + (AW+1)'(1);
            end else if (pop && !push) begin
                cnt_q <= cnt_q - (AW+1)'(1);
            end
        end
    end

    assign rdata = mem_q[rptr_q];
    assign count = cnt_q;
    assign full  = (cnt_q == (AW+1)'(DEPTH));
    assign empty = (cnt_q == '0);

endmodule

// File: rtl/unstripe.sv
// Two-lane to one-stream merger with strict lane0/lane1 alternation.
// Error detection is compiled in only when UNSTRIPE_ERR_EN is defined.
module unstripe
    import stripe_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic             clk_2f,
    input  logic             reset,
    input  logic [WIDTH-1:0] lane0,
    input  logic             valid0,
    input  logic [WIDTH-1:0] lane1,
    input  logic             valid1,
    output logic [WIDTH-1:0] dataOut,
    output logic             validOut,
    output logic             full0,
    output logic             full1,
    output logic             err_overflow,
    output logic             err_skew
);

    localparam int CW = $clog2(DEPTH) + 1;

    sel_state_e       state_q;
    logic [WIDTH-1:0] data_q;
    logic             valid_q;

    logic [WIDTH-1:0] rdata0, rdata1;
    logic [CW-1:0]    cnt0, cnt1;
    logic             f0, f1, e0, e1;
    logic             pop0, pop1, push0, push1;

    assign pop0  = (state_q == EXPECT0) && !e0;
    assign pop1  = (state_q == EXPECT1) && !e1;
    assign push0 = valid0 && ((cnt0 != CW'(DEPTH)) || pop0);
    assign push1 = valid1 && ((cnt1 != CW'(DEPTH)) || pop1);

    lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
        .clk   (clk_2f),
        .rst_n (reset),
        .push  (push0),
        .pop   (pop0),
        .wdata (lane0),
        .rdata (rdata0),
        .count (cnt0),
        .full  (f0),
        .empty (e0)
    );

    lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
        .clk   (clk_2f),
        .rst_n (reset),
        .push  (push1),
        .pop   (pop1),
        .wdata (lane1),
        .rdata (rdata1),
        .count (cnt1),
        .full  (f1),
        .empty (e1)
    );

    // Selector FSM: pop the expected lane's head, never skip a lane.
    always_ff @(posedge clk_2f) begin
        if (!reset) begin
            state_q <= EXPECT0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                EXPECT0: begin
                    if (!e0) begin
                        data_q  <= rdata0;
                        valid_q <= 1'b1;
                        state_q <= EXPECT1;
                    end else begin
                        valid_q <= 1'b0;
                    end
                end
                EXPECT1: begin
                    if (!e1) begin
                        data_q  <= rdata1;
                        valid_q <= 1'b1;
                        state_q <= EXPECT0;
                    end else begin
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= EXPECT0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign dataOut  = data_q;
    assign validOut = valid_q;
    assign full0    = f0;
    assign full1    = f1;

`ifdef UNSTRIPE_ERR_EN
    logic ovf_q, skew_q;
    logic ovf_d, skew_d;

    assign ovf_d  = (valid0 && !push0) || (valid1 && !push1);
    assign skew_d = ((state_q == EXPECT0) && e0 && f1)
                 || ((state_q == EXPECT1) && e1 && f0);

    // Sticky error flags; cleared only by reset.
    always_ff @(posedge clk_2f) begin
        if (!reset) begin
            ovf_q  <= 1'b0;
            skew_q <= 1'b0;
        end else begin
            if (ovf_d) begin
                ovf_q <= 1'b1;
            end
            if (skew_d) begin
                skew_q <= 1'b1;
            end
        end
    end

    assign err_overflow = ovf_q;
    assign err_skew     = skew_q;
`else
    assign err_overflow = 1'b0;
    assign err_skew     = 1'b0;
`endif

endmodule

// File: tb/tb_unstripe.sv
// Self-checking bench for unstripe: directed plan steps plus random
// traffic against a queue-based reference of the merge rules.
module tb_unstripe;

    localparam int W = 32;
    localparam int D = 4;

    logic         clk;
    logic         reset;
    logic [W-1:0] lane0, lane1;
    logic         valid0, valid1;
    logic [W-1:0] dataOut;
    logic         validOut, full0, full1;
    logic         err_overflow, err_skew;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    bit           want1;
    logic [W-1:0] m_data;
    bit           m_valid;
    bit           m_ovf;
    bit           m_skew;

    unstripe #(.WIDTH(W), .DEPTH(D)) dut (
        .clk_2f       (clk),
        .reset        (reset),
        .lane0        (lane0),
        .valid0       (valid0),
        .lane1        (lane1),
        .valid1       (valid1),
        .dataOut      (dataOut),
        .validOut     (validOut),
        .full0        (full0),
        .full1        (full1),
        .err_overflow (err_overflow),
        .err_skew     (err_skew)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit rn, input bit v0, input logic [W-1:0] d0,
                              input bit v1, input logic [W-1:0] d1);
        bit skew_now;
        if (!rn) begin
            q0.delete();
            q1.delete();
            want1   = 0;
            m_data  = '0;
            m_valid = 0;
            m_ovf   = 0;
            m_skew  = 0;
        end else begin
            skew_now = want1 ? (q1.size() == 0 && q0.size() == D)
                             : (q0.size() == 0 && q1.size() == D);
            if (skew_now) m_skew = 1;
            m_valid = 0;
            if (!want1 && q0.size() > 0) begin
                m_data  = q0.pop_front();
                m_valid = 1;
                want1   = 1;
            end else if (want1 && q1.size() > 0) begin
                m_data  = q1.pop_front();
                m_valid = 1;
                want1   = 0;
            end
            if (v0) begin
                if (q0.size() < D) q0.push_back(d0);
                else m_ovf = 1;
            end
            if (v1) begin
                if (q1.size() < D) q1.push_back(d1);
                else m_ovf = 1;
            end
        end
    endtask

    task automatic step(input bit rn, input bit v0, input logic [W-1:0] d0,
                        input bit v1, input logic [W-1:0] d1);
        bit eo, es;
        @(negedge clk);
        reset  = rn;
        valid0 = v0;
        lane0  = d0;
        valid1 = v1;
        lane1  = d1;
        @(posedge clk);
        model_edge(rn, v0, d0, v1, d1);
        #1;
`ifdef UNSTRIPE_ERR_EN
        eo = m_ovf;
        es = m_skew;
`else
        eo = 0;
        es = 0;
`endif
        chk("validOut", W'(validOut), W'(m_valid));
        chk("dataOut", dataOut, m_data);
        chk("full0", W'(full0), W'(q0.size() == D));
        chk("full1", W'(full1), W'(q1.size() == D));
        chk("err_overflow", W'(err_overflow), W'(eo));
        chk("err_skew", W'(err_skew), W'(es));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, '0, 0, '0);
    endtask

    initial begin
        int p0, p1;
        reset  = 0;
        valid0 = 0;
        valid1 = 0;
        lane0  = '0;
        lane1  = '0;

        // reset held with valids high
        for (int i = 0; i < 3; i++) step(0, 1, 32'hDEAD0000 + i, 1, 32'hBEEF0000 + i);
        chk("rst_validOut", W'(validOut), '0);
        chk("rst_dataOut", dataOut, '0);

        // alternating arrivals
        step(1, 1, 32'hA0, 0, '0);
        step(1, 0, '0, 1, 32'hB0);
        step(1, 1, 32'hA1, 0, '0);
        step(1, 0, '0, 1, 32'hB1);
        idle(3);

        // lane1 leads by several cycles
        step(1, 0, '0, 1, 32'h1B0);
        step(1, 0, '0, 1, 32'h1B1);
        idle(2);
        step(1, 1, 32'h1A0, 0, '0);
        step(1, 1, 32'h1A1, 0, '0);
        idle(5);

        // lane0 only: stall at EXPECT1, fill, skew, overflow
        for (int i = 0; i < 7; i++) step(1, 1, 32'h200 + i, 0, '0);
        idle(2);
        step(0, 0, '0, 0, '0);

        // push and pop on a full lane0 FIFO in EXPECT0
        step(1, 1, 32'h300, 0, '0);
        for (int i = 1; i < 6; i++) step(1, 1, 32'h300 + i, 0, '0);
        step(1, 0, '0, 1, 32'h3B0);
        step(1, 1, 32'h310, 0, '0);
        step(1, 1, 32'h311, 1, 32'h3B1);
        idle(8);

        // mid-stream reset with words buffered
        step(1, 1, 32'h400, 0, '0);
        step(1, 1, 32'h401, 0, '0);
        step(1, 1, 32'h402, 0, '0);
        step(1, 1, 32'h403, 0, '0);
        step(0, 1, 32'h4FF, 1, 32'h4FE);
        step(1, 1, 32'h410, 0, '0);
        step(1, 0, '0, 0, '0);
        idle(2);

        // random traffic with varying lane rates
        for (int blk = 0; blk < 8; blk++) begin
            p0 = $urandom_range(10, 95);
            p1 = $urandom_range(10, 95);
            for (int i = 0; i < 80; i++) begin
                step(($urandom_range(0, 99) >= 2),
                     ($urandom_range(0, 99) < p0), $urandom,
                     ($urandom_range(0, 99) < p1), $urandom);
            end
        end
        idle(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/unstripe.md
# unstripe

Two-lane to one-stream merger: receiver-side counterpart of the `stripe` block. It accepts 32-bit words on `lane0`/`lane1` with per-lane valids, buffers each lane in a small FIFO, and re-serialises them in strict alternation (lane0, lane1, lane0, …) onto `dataOut`/`validOut`. It sits after the lane transport, so the original word order is recovered regardless of inter-lane skew up to the FIFO depth.

## Interface
- `WIDTH`, 32, data word width.
- `DEPTH`, 4, per-lane FIFO depth in words; must be a power of two, ≥2.
- `clk_2f` in 1 — single clock; all logic on its rising edge.
- `reset` in 1 — synchronous, active-low; sampled on `clk_2f`.
- `lane0` in WIDTH — lane 0 word.
- `valid0` in 1 — lane 0 word valid this cycle.
- `lane1` in WIDTH — lane 1 word.
- `valid1` in 1 — lane 1 word valid this cycle.
- `dataOut` out WIDTH — merged word, registered.
- `validOut` out 1 — `dataOut` valid, registered.
- `full0` out 1 — lane 0 FIFO holds DEPTH words.
- `full1` out 1 — lane 1 FIFO holds DEPTH words.
- `err_overflow` out 1 — sticky; a valid word was dropped.
- `err_skew` out 1 — sticky; lane skew exceeded buffering.

## Operation
- Push: on each edge, `laneN` is written to FIFO N when `validN`=1 and (count<DEPTH, or FIFO N is popped that same edge). Both lanes may push on the same edge.
- Drop: `validN`=1 with FIFO N full and not popped → word discarded, count unchanged, `err_overflow` set.
- Selector FSM, two states: EXPECT0, EXPECT1. Reset state EXPECT0.
  - EXPECT0: FIFO0 non-empty → pop head to `dataOut`, `validOut`=1, go EXPECT1; else `validOut`=0, stay.
  - EXPECT1: same with FIFO1, next state EXPECT0.
- The selector never skips a lane; an empty expected lane stalls output even if the other lane holds data.
- Skew error: in EXPECTn, FIFO n empty while the other FIFO is full → `err_skew` set (sticky). No resync; recovery is by reset.
- `validOut`=0 cycles: `dataOut` holds its last value.
- Pop uses the FIFO contents before the edge; a word pushed on edge k is first poppable on edge k+1.
- Reset (`reset`=0 at an edge, including mid-stream): both FIFOs flushed (pointers and counts to 0), FSM→EXPECT0, `dataOut`=0, `validOut`=0, `full0`=`full1`=0, both error flags cleared. Inputs on that edge are ignored.

## Timing
- Latency: word sampled on edge k appears on `dataOut` after edge k+1 at the earliest (1 cycle), more if stalled behind the other lane.
- Throughput: at most one output word per cycle; sustained full rate needs alternating lane arrivals (or both lanes at half rate).
- `full0`/`full1` are derived from the registered count and reflect the post-edge state; no combinational path from `validN` to `fullN`.
- Count arithmetic: count width log2(DEPTH)+1; pointers log2(DEPTH) bits and wrap naturally at DEPTH.
- Simultaneous push and pop on the same FIFO: count unchanged, both take effect.

## Configuration
- `UNSTRIPE_ERR_EN`: when defined, the overflow and skew detection logic is compiled in and `err_overflow`/`err_skew` behave as above.
- Without it: both ports remain but are tied to 0; drops still occur silently on overflow; no detection logic is synthesised.

## Structure
- Shared package `stripe_pkg`: `WIDTH` default, the FSM state encoding (EXPECT0=1'b0, EXPECT1=1'b1), and the `DEPTH` default. `stripe` and `unstripe` both import it.
- Sub-module `lane_fifo` (WIDTH, DEPTH; push/pop/data/count/full/empty, synchronous active-low reset), instantiated once per lane. The top holds the FSM, output registers and error flags.

## Test plan
- Reset: hold `reset`=0 three cycles with `valid0`=`valid1`=1 → `validOut`=0, `dataOut`=0, `full0`=`full1`=0, errors 0.
- Alternating: lane0 A0 (edge 1), lane1 B0 (edge 2), lane0 A1 (edge 3), lane1 B1 (edge 4) → `dataOut` A0, B0, A1, B1 after edges 2–5, `validOut` continuous.
- Skew: lane1 sends B0, B1 on edges 1–2, lane0 sends A0, A1 on edges 5–6 → no output before edge 6; then A0, B0, A1, B1 on consecutive cycles.
- Overflow (DEPTH=4, macro on): five lane0 words, no lane1 → first popped after 1 cycle. FSM stalls at EXPECT1 with 4 buffered, then `full0`=1 and `err_skew`=1; the next lane0 word sets `err_overflow`=1; with macro off both flags stay 0.
- Simultaneous push/pop: FIFO0 full, EXPECT0, `valid0`=1 → one word out, new word accepted, `full0` stays 1, no overflow.
- Mid-stream reset: 3 words buffered, assert reset one cycle → outputs cleared. First post-reset lane0 word is emitted one cycle after it is sampled.
